// File: rtl/genius_sequence_player_pkg.sv
// Shared definitions for the Genius sequence player: colour codes, state encoding.
// Pure declarations, no timing.
// Not applicable (no handshake).
package genius_sequence_player_pkg;

  localparam logic [3:0] CODE_OFF    = 4'b0000;
  localparam logic [3:0] CODE_RED    = 4'b0001;
  localparam logic [3:0] CODE_GREEN  = 4'b0010;
  localparam logic [3:0] CODE_BLUE   = 4'b0100;
  localparam logic [3:0] CODE_YELLOW = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  // Map a stored 2-bit colour index to the VGA driver's colour code
  function automatic logic [3:0] idx_to_code(input logic [1:0] idx);
    logic [3:0] code;
    case (idx)
      2'b00:   code = CODE_RED;
      2'b01:   code = CODE_GREEN;
      2'b10:   code = CODE_BLUE;
      default: code = CODE_YELLOW;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/genius_sequence_player_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying random colour indices.
// New value visible one cycle after advance is sampled high.
// Holds its value whenever advance is low.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  // An all-zero state would lock the register up, so a zero seed is remapped
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_value;

  // Shift left, feeding back the XOR of bits 16,14,13,11 (1-based)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= SEED_EFF;
    end else if (advance) begin
      r_value <= {r_value[14:0], r_value[15] ^ r_value[13] ^ r_value[12] ^ r_value[10]};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/genius_sequence_player.sv
// Stores the Genius colour sequence, appends one random colour per round, and flashes it to the VGA driver.
// start in IDLE at T -> busy at T+1, first flash at T+2, done at T+2+seq_len*(ON_TICKS+OFF_TICKS).
// start/clear are ignored while a round is running; there is no queuing.
module genius_sequence_player #(
  parameter int          MAX_LEN   = 32,
  parameter int          ON_TICKS  = 25000000,
  parameter int          OFF_TICKS = 12500000,
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic       full,
  output logic [6:0] seq_len,
  output logic [3:0] signal,
  output logic       enable,
  input  logic [5:0] rd_addr,
  output logic [3:0] rd_code
);

  import genius_sequence_player_pkg::*;

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_idx, w_next_idx;
  logic [TW-1:0] r_tick, w_next_tick;
  logic [6:0]    r_seq_len;
  logic          r_full;
  logic [1:0]    r_mem [MAX_LEN];
  logic          r_busy, r_done, r_enable;
  logic [3:0]    r_signal;

  logic          w_append;
  logic          w_seq_clr;
  logic          w_lfsr_adv;
  logic          w_last_idx;
  logic [1:0]    w_show_idx;
  logic [15:0]   w_lfsr;
  logic [13:0]   w_unused_lfsr;

  assign w_unused_lfsr = w_lfsr[15:2];
  assign w_last_idx    = ({{(7-AW){1'b0}}, r_idx} == (r_seq_len - 7'd1));

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (w_lfsr_adv),
    .value   (w_lfsr)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state, flash index/tick and append/clear/LFSR control
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_tick  = r_tick;
    w_append     = 1'b0;
    w_seq_clr    = 1'b0;
    w_lfsr_adv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_lfsr_adv = !start;
        if (clear)      w_seq_clr    = 1'b1;
        else if (start) w_next_state = S_APPEND;
      end
      S_APPEND: begin
        // When the memory is full the stored sequence is replayed untouched
        w_append     = (r_seq_len < 7'(MAX_LEN));
        w_lfsr_adv   = w_append;
        w_next_idx   = '0;
        w_next_tick  = '0;
        w_next_state = S_SHOW;
      end
      S_SHOW: begin
        if (r_tick == ON_LAST) begin
          w_next_tick  = '0;
          w_next_state = S_GAP;
        end else begin
          w_next_tick = r_tick + TW'(1);
        end
      end
      S_GAP: begin
        if (r_tick == OFF_LAST) begin
          w_next_tick = '0;
          if (w_last_idx) begin
            w_next_state = S_DONE;
          end else begin
            w_next_idx   = r_idx + AW'(1);
            w_next_state = S_SHOW;
          end
        end else begin
          w_next_tick = r_tick + TW'(1);
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Colour index for the next flash; bypasses the entry being written this cycle
  always_comb begin
    w_show_idx = r_mem[w_next_idx];
    if (w_append && (w_next_idx == r_seq_len[AW-1:0])) w_show_idx = w_lfsr[1:0];
  end

  // Flash index and tick counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx  <= '0;
      r_tick <= '0;
    end else begin
      r_idx  <= w_next_idx;
      r_tick <= w_next_tick;
    end
  end

  // Sequence length and full flag (full lags seq_len by one cycle)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq_len <= '0;
      r_full    <= 1'b0;
    end else begin
      r_full <= (r_seq_len == 7'(MAX_LEN));
      if (w_seq_clr)     r_seq_len <= '0;
      else if (w_append) r_seq_len <= r_seq_len + 7'd1;
    end
  end

  // Sequence memory; entries beyond seq_len are never observed, so no reset
  always_ff @(posedge clock) begin
    if (w_append) r_mem[r_seq_len[AW-1:0]] <= w_lfsr[1:0];
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_enable <= 1'b0;
      r_signal <= CODE_OFF;
    end else begin
      r_busy   <= (w_next_state == S_APPEND) || (w_next_state == S_SHOW) || (w_next_state == S_GAP);
      r_done   <= (w_next_state == S_DONE);
      r_enable <= (w_next_state == S_SHOW);
      r_signal <= (w_next_state == S_SHOW) ? idx_to_code(w_show_idx) : CODE_OFF;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign enable  = r_enable;
  assign signal  = r_signal;
  assign seq_len = r_seq_len;
  assign full    = r_full;
  assign rd_code = ({1'b0, rd_addr} < r_seq_len) ? idx_to_code(r_mem[rd_addr[AW-1:0]]) : CODE_OFF;

endmodule
